// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
// Sequential AES InvSubBytes stage. A 128-bit state is accepted from the
// InvShiftRows stage, and its 16 bytes are replaced in place by InvSbox(byte).
// The work is spread over several cycles, walking a byte counter through the
// state in byte order k = 0..15. Byte k lives at bits [127-8k -: 8].
//
// Build option:
//   INV_SBOX_QUAD_EN  defined   -> four InvSbox lanes, 4 RUN cycles per state
//   INV_SBOX_QUAD_EN  undefined -> one InvSbox lane, 16 RUN cycles per state
// The interface and the handshake are the same in both builds.

// InvSbox
// Computes the AES inverse S-box arithmetically. The inverse affine map is
// applied first, then the multiplicative inverse in GF(2^8) modulo
// x^8+x^4+x^3+x+1, with 0 mapped to 0.
module InvSbox (
  input  logic [7:0] val_i,
  output logic [7:0] val_o
);

  // GF(2^8) multiply: shift-and-add with reduction by 0x1B.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc;
    prod = 8'h00;
    acc  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        prod = prod ^ acc;
      end
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1B : 8'h00);
    end
    return prod;
  endfunction

  // GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128, so 0 maps to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gfMul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] affineVal;

  // Inverse affine map y = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 0x05, then invert.
  always_comb begin
    affineVal = {val_i[6:0], val_i[7]}
              ^ {val_i[4:0], val_i[7:5]}
              ^ {val_i[1:0], val_i[7:2]}
              ^ 8'h05;
    val_o = gfInv(affineVal);
  end

endmodule

// inv_sub_bytes_seq
// Top-level controller. Three states:
//   IDLE : ready for a new state. Accepting it loads the working register.
//   RUN  : substitutes Lanes bytes per cycle, starting at the byte counter.
//   DONE : presents the result until the downstream handshake completes.
// All outputs are driven straight from registers.
module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

`ifdef INV_SBOX_QUAD_EN
  localparam int Lanes = 4;
`else
  localparam int Lanes = 1;
`endif

  // The counter value of the final RUN cycle. The step between counter values is one lane group.
  localparam logic [3:0] LastIdx  = 4'(16 - Lanes);
  localparam logic [3:0] LaneStep = 4'(Lanes);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] data_q;
  logic [127:0] data_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [7:0]   laneIn  [Lanes];
  logic [7:0]   laneOut [Lanes];

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = data_q;

  // Each lane reads the byte at counter + lane and substitutes it.
  for (genvar g = 0; g < Lanes; g++) begin : gLane
    assign laneIn[g] = data_q[127 - 8*(int'(cnt_q) + g) -: 8];
    InvSbox uInvSbox (
      .val_i (laneIn[g]),
      .val_o (laneOut[g])
    );
  end

  // Working state after this cycle's lanes write their results back in place.
  always_comb begin
    data_d = data_q;
    for (int j = 0; j < Lanes; j++) begin
      data_d[127 - 8*(int'(cnt_q) + j) -: 8] = laneOut[j];
    end
  end

  // Controller FSM, with registered handshake outputs and the working register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      data_q      <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= data_in;
            cnt_q      <= 4'd0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          data_q <= data_d;
          if (cnt_q == LastIdx) begin
            // Leave RUN before the counter would wrap past byte 15.
            cnt_q       <= 4'd0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + LaneStep;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= 4'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq
// Directed bench for inv_sub_bytes_seq. Expected bytes come from the FIPS-197
// inverse S-box table. The expected latency follows INV_SBOX_QUAD_EN.
module tb_inv_sub_bytes_seq;

`ifdef INV_SBOX_QUAD_EN
  localparam int ExpLat = 4;
`else
  localparam int ExpLat = 16;
`endif

  localparam logic [7:0] InvTbl [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int           total;
  int           bad;
  vec_t         vecs [18];
  logic [127:0] tmpIn;
  logic [127:0] tmpOut;

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits for in_ready, then presents one state for a single accepting edge.
  task automatic loadState(input logic [127:0] din, input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("%s_in_ready", name), 128'(in_ready), 128'(1));
    data_in  = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = ~din;
    checkOutput($sformatf("%s_busy_run", name), {126'h0, busy, in_ready}, 128'h2);
  endtask

  // Counts edges from acceptance to out_valid and checks the latency.
  task automatic waitDone(input string name);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("%s_latency", name), 128'(lat), 128'(ExpLat));
  endtask

  // Full transaction: load, wait, check result, handshake, check IDLE again.
  task automatic applyStimulus(input logic [127:0] din, input logic [127:0] exp, input string name);
    loadState(din, name);
    waitDone(name);
    checkOutput($sformatf("%s_data", name), data_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput($sformatf("%s_ack", name), {125'h0, out_valid, busy, in_ready}, 128'h1);
  endtask

  // Streams four states with both handshakes tied high and checks spacing and order.
  task automatic runBackToBack();
    int   sent;
    int   got;
    int   lastOut;
    logic rdy;
    sent    = 0;
    got     = 0;
    lastOut = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = vecs[2].din;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid) begin
        sent++;
        if (sent < 4) begin
          data_in = vecs[2 + sent].din;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        checkOutput($sformatf("b2b_data%0d", got), data_out, vecs[2 + got].dout);
        if (lastOut >= 0) begin
          checkOutput($sformatf("b2b_gap%0d", got), 128'(cyc - lastOut), 128'(ExpLat + 2));
        end
        lastOut = cyc;
        got++;
      end
    end
    checkOutput("b2b_results", 128'(got), 128'(4));
    checkOutput("b2b_accepted", 128'(sent), 128'(4));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Main sequence: reset, vector table, hold in DONE, reset abort, streaming.
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 128'h0;

    vecs[0] = '{128'h0, {16{8'h52}}, "zeros"};
    vecs[1] = '{128'h637C777B_F26B6FC5_3001672B_FED7AB76,
                128'h00010203_04050607_08090A0B_0C0D0E0F, "fips"};
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) begin
        tmpIn[127 - 8*k -: 8]  = 8'(16*s + k);
        tmpOut[127 - 8*k -: 8] = InvTbl[16*s + k];
      end
      vecs[2 + s] = '{tmpIn, tmpOut, $sformatf("sweep%0d", s)};
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", {126'h0, out_valid, busy}, 128'h0);
    checkOutput("reset_data", data_out, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_ready", {126'h0, in_ready, busy}, 128'h2);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].din, vecs[i].dout, vecs[i].name);
    end

    // Hold in DONE with in_valid asserted and data_in changing.
    loadState(vecs[1].din, "hold");
    waitDone("hold");
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checkOutput($sformatf("hold_flags%0d", c), {125'h0, out_valid, busy, in_ready}, 128'h6);
      checkOutput($sformatf("hold_data%0d", c), data_out, vecs[1].dout);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("hold_release", {125'h0, out_valid, busy, in_ready}, 128'h1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_no_capture", {125'h0, out_valid, busy, in_ready}, 128'h1);

    // Reset in the middle of RUN discards the partial state.
    loadState({16{8'hFF}}, "abort");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_flags", {126'h0, out_valid, busy}, 128'h0);
    checkOutput("abort_data", data_out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", 128'(in_ready), 128'(1));
    applyStimulus(vecs[0].din, vecs[0].dout, "after_abort");

    runBackToBack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 The block SHALL have no parameters; lane count is selected only by the Configuration macro.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (InvShiftRows output) state valid.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 data_in  input  128  AES state; byte k at bits [127-8k -: 8], k=0..15, column-major as elsewhere in the codebase.
REQ-007 out_valid  output  1  data_out holds a completed InvSubBytes result.
REQ-008 out_ready  input  1  downstream accepts data_out.
REQ-009 data_out  output  128  working state register, same byte ordering as data_in.
REQ-010 busy  output  1  high in RUN and DONE.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE, encoded in a registered state variable.
REQ-012 IDLE: in_ready=1; on in_valid=1 the block SHALL load data_in into the working register, clear the byte counter, and enter RUN.
REQ-013 RUN: each cycle the block SHALL replace L consecutive bytes starting at counter index with InvSbox(byte) in place and advance the counter by L (L=1 serial, L=4 quad).
REQ-014 RUN SHALL last exactly 16/L cycles; after the cycle processing the last byte (index 15), the next state SHALL be DONE.
REQ-015 Counter width SHALL be 4 bits; it SHALL NOT wrap during RUN because the exit to DONE occurs at the last increment.
REQ-016 DONE: out_valid=1, data_out stable; on out_ready=1 the block SHALL return to IDLE; with out_ready=0 it SHALL hold indefinitely.
REQ-017 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and data_in SHALL not be sampled.
REQ-018 A new state SHALL be accepted no earlier than the cycle after the DONE handshake (one IDLE cycle minimum between results).
REQ-019 Latency: with acceptance at edge T, out_valid SHALL rise at edge T+16/L (T+16 serial, T+4 quad).
REQ-020 InvSbox SHALL be computed arithmetically: y = rotl(b,1)^rotl(b,3)^rotl(b,6)^0x05, then multiplicative inverse of y in GF(2^8) mod x^8+x^4+x^3+x+1, with inverse(0)=0.
REQ-021 InvSbox SHALL match FIPS-197 for all 256 inputs (e.g. 0x63->0x00, 0x00->0x52, 0x01->0x09, 0xFE->0x0C).
REQ-022 data_out content SHALL be meaningful only while out_valid=1; intermediate values in RUN are don't-care to consumers.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, counter=0, working register=128'h0, out_valid=0, busy=0; in_ready SHALL be 1 once rst deasserts.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no output produced; the partially substituted state SHALL be discarded.

Configuration
REQ-025 Macro INV_SBOX_QUAD_EN defined: four InvSbox instances, L=4, RUN lasts 4 cycles.
REQ-026 Macro INV_SBOX_QUAD_EN undefined: one InvSbox instance, L=1, RUN lasts 16 cycles; interface and handshake SHALL be identical in both builds.

Verification
REQ-027 Load 128'h00000000_00000000_00000000_00000000 -> data_out 128'h52525252_52525252_52525252_52525252 at T+16 (T+4 quad).
REQ-028 Load bytes 0x63,0x7C,0x77,0x7B,0xF2,0x6B,0x6F,0xC5,0x30,0x01,0x67,0x2B,0xFE,0xD7,0xAB,0x76 -> data_out 128'h00010203_04050607_08090A0B_0C0D0E0F.
REQ-029 Hold out_ready=0 for 20 cycles in DONE with in_valid=1 and changing data_in -> out_valid and data_out unchanged, in_ready=0, no new capture.
REQ-030 Assert rst at RUN cycle 5 -> same cycle out_valid=0, busy=0, data_out=0; after release, new state 128'h0 produces all-0x52 with full latency.
REQ-031 Exhaustive byte sweep: 16 states covering inputs 0x00..0xFF -> every byte matches FIPS-197 InvSbox table in both macro builds.
REQ-032 Back-to-back: out_ready tied 1, in_valid tied 1 -> results every 16/L+2 cycles, none lost or duplicated.
